// File: rtl/prbs_frame_ctrl.sv
// Frame sequencer for the 15-bit PRBS scrambler datapath.
// Feeds nibbles MSB first and returns scrambled nibbles over valid/ready.
module prbs_frame_ctrl #(
  parameter int FRAME_NIBBLES = 24,
  parameter int SEED_W        = 15,
  parameter int CNT_W         = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [SEED_W-1:0] seed,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        out_data,
  output logic              busy,
  output logic              frame_done,
  output logic              lfsr_en,
  output logic              lfsr_load,
  output logic [SEED_W-1:0] lfsr_seed,
  output logic              prbs_in,
  input  logic [3:0]        hex_in
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_SHIFT,
    S_CAP,
    S_OUT
  } state_e;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_NIBBLES);

  state_e            state_q;
  logic [SEED_W-1:0] seed_q;
  logic [CNT_W-1:0]  nib_q;
  logic [1:0]        bit_q;
  logic [3:0]        dat_q;
  logic              in_ready_q;
  logic              out_valid_q;
  logic [3:0]        out_data_q;
  logic              busy_q;
  logic              done_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      seed_q      <= '0;
      nib_q       <= '0;
      bit_q       <= '0;
      dat_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort && state_q != S_IDLE) begin
        state_q     <= S_IDLE;
        in_ready_q  <= 1'b0;
        out_valid_q <= 1'b0;
        busy_q      <= 1'b0;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (start) begin
              seed_q  <= seed;
              nib_q   <= '0;
              busy_q  <= 1'b1;
              state_q <= S_LOAD;
            end
          end
          S_LOAD: begin
            in_ready_q <= 1'b1;
            state_q    <= S_WAIT;
          end
          S_WAIT: begin
            if (in_valid) begin
              dat_q      <= in_data;
              bit_q      <= '0;
              in_ready_q <= 1'b0;
              state_q    <= S_SHIFT;
            end
          end
          S_SHIFT: begin
            bit_q <= bit_q + 2'd1;
            if (bit_q == 2'd3) state_q <= S_CAP;
          end
          S_CAP: begin
            out_data_q  <= hex_in;
            out_valid_q <= 1'b1;
            nib_q       <= nib_q + 1'b1;
            state_q     <= S_OUT;
          end
          S_OUT: begin
            if (out_ready) begin
              out_valid_q <= 1'b0;
              if (nib_q == LAST) begin
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
                state_q <= S_IDLE;
              end else begin
                in_ready_q <= 1'b1;
                state_q    <= S_WAIT;
              end
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  // Datapath strobes decode straight from state so they align with SHIFT/LOAD.
  assign lfsr_load  = (state_q == S_LOAD);
  assign lfsr_en    = (state_q == S_SHIFT);
  assign prbs_in    = lfsr_en & dat_q[2'd3 - bit_q];
  assign lfsr_seed  = seed_q;
  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_prbs_frame_ctrl.sv
// Scoreboard bench for prbs_frame_ctrl with a behavioural datapath
// and a keystream reference model.
module tb_prbs_frame_ctrl;

  localparam int FN = 24;
  localparam int SW = 15;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          abort;
  logic [SW-1:0] seed;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_data;
  logic          out_valid;
  logic          out_ready;
  logic [3:0]    out_data;
  logic          busy;
  logic          frame_done;
  logic          lfsr_en;
  logic          lfsr_load;
  logic [SW-1:0] lfsr_seed;
  logic          prbs_in;
  logic [3:0]    hex_in;

  prbs_frame_ctrl #(
    .FRAME_NIBBLES(FN),
    .SEED_W(SW),
    .CNT_W(5)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .abort(abort),
    .seed(seed),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .busy(busy),
    .frame_done(frame_done),
    .lfsr_en(lfsr_en),
    .lfsr_load(lfsr_load),
    .lfsr_seed(lfsr_seed),
    .prbs_in(prbs_in),
    .hex_in(hex_in)
  );

  always #5 clk = ~clk;

  // stand-in for the scrambler datapath
  logic [SW-1:0] dp_lfsr = '0;
  logic [3:0]    dp_hex  = '0;
  always @(posedge clk) begin
    if (lfsr_load) dp_lfsr <= lfsr_seed;
    else if (lfsr_en) begin
      dp_hex  <= {dp_hex[2:0], prbs_in ^ dp_lfsr[14]};
      dp_lfsr <= {dp_lfsr[13:0], dp_lfsr[14] ^ dp_lfsr[13]};
    end
  end
  assign hex_in = dp_hex;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // reference model: keystream is bit 14 of the sequence, packed MSB first
  int         m_ks;
  int         m_cnt;
  logic [4:0] sb[$];
  logic [3:0] got[$];

  task automatic model_start(input int s);
    m_ks  = s & 32'h7FFF;
    m_cnt = 0;
  endtask

  task automatic model_push(input logic [3:0] p);
    int k;
    k = 0;
    for (int i = 0; i < 4; i++) begin
      k    = k * 2 + ((m_ks >> 14) & 1);
      m_ks = (m_ks * 2 + (((m_ks >> 14) ^ (m_ks >> 13)) & 1)) & 32'h7FFF;
    end
    m_cnt++;
    sb.push_back({(m_cnt == FN), p ^ 4'(k)});
  endtask

  int         cyc = 0;
  int         acc_cyc = 0;
  int         rise_cyc = 0;
  int         load_cnt = 0;
  int         en_cnt = 0;
  int         done_cnt = 0;
  int         out_cnt = 0;
  int         rmode = 0;
  logic [3:0] last_out = '0;
  logic [3:0] held = '0;
  logic       prev_ov = 1'b0;
  logic       stalled = 1'b0;
  logic       chk_done = 1'b0;

  always @(posedge clk) cyc++;

  // monitor
  always @(negedge clk) begin
    logic [4:0] e;
    check("en_load_excl", {31'b0, lfsr_en & lfsr_load}, 0);
    if (reset) begin
      prev_ov  = 1'b0;
      stalled  = 1'b0;
      chk_done = 1'b0;
    end else begin
      if (lfsr_load) load_cnt++;
      if (lfsr_en) en_cnt++;
      if (frame_done) done_cnt++;
      if (chk_done) begin
        check("frame_done_pulse", frame_done, 1);
        check("busy_drop", busy, 0);
        chk_done = 1'b0;
      end
      if (stalled) begin
        check("stall_valid", out_valid, 1);
        check("stall_data", out_data, held);
        check("stall_en", lfsr_en, 0);
        check("stall_in_ready", in_ready, 0);
      end
      if (out_valid && !prev_ov) rise_cyc = cyc;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) check("unexpected_out", 1, 0);
        else begin
          e = sb.pop_front();
          check("out_data", out_data, e[3:0]);
          if (e[4]) chk_done = 1'b1;
        end
        got.push_back(out_data);
        last_out = out_data;
        out_cnt++;
      end
      stalled = out_valid && !out_ready;
      held    = out_data;
      prev_ov = out_valid;
    end
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        0: out_ready = 1'b1;
        1: out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [SW-1:0] s);
    start = 1'b1;
    seed  = s;
    tick();
    start = 1'b0;
    model_start(int'(s));
  endtask

  task automatic do_abort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic send(input logic [3:0] n, input int gap);
    bit ok;
    repeat (gap) tick();
    in_valid = 1'b1;
    in_data  = n;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      acc_cyc = cyc;
      model_push(n);
    end else check("accept_timeout", 0, 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_outs(input int n);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (out_cnt >= n) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("output_timeout", 0, 1);
    tick();
  endtask

  task automatic wait_valid();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("valid_timeout", 0, 1);
    tick();
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_data"}, out_data, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_frame_done"}, frame_done, 0);
    check({tag, "_lfsr_en"}, lfsr_en, 0);
    check({tag, "_lfsr_load"}, lfsr_load, 0);
    check({tag, "_lfsr_seed"}, lfsr_seed, 0);
  endtask

  logic [3:0] fr [FN] = '{4'hA, 4'hC, 4'hB, 4'hC, 4'hD, 4'h2, 4'h1, 4'h1,
                          4'h4, 4'hD, 4'hA, 4'hE, 4'h1, 4'h5, 4'h7, 4'h7,
                          4'hC, 4'h6, 4'hD, 4'hB, 4'hF, 4'h4, 4'hC, 4'h9};

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [SW-1:0] s;
    logic [3:0]    ref_run [4];
    logic [3:0]    first0;
    int            base;
    int            d0;
    reset    = 1'b1;
    start    = 1'b0;
    abort    = 1'b0;
    seed     = '0;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (3) tick();
    @(negedge clk);
    check_reset_outs("reset");
    tick();
    reset = 1'b0;
    tick();

    // pass-through with an all-zero seed
    load_cnt = 0;
    en_cnt   = 0;
    base     = out_cnt;
    do_start('0);
    send(4'hA, 1);
    wait_outs(base + 1);
    check("pt_load_cycles", load_cnt, 1);
    check("pt_en_cycles", en_cnt, 4);
    check("pt_latency", rise_cyc - acc_cyc, 6);
    check("pt_data", last_out, 4'hA);
    do_abort();
    @(negedge clk);
    check("pt_abort_busy", busy, 0);
    tick();

    // known keystream, then continuation without reseed
    base = out_cnt;
    do_start(15'h4000);
    send(4'h0, 0);
    wait_outs(base + 1);
    check("ks_first", last_out, 4'h8);
    send(4'hF, 2);
    wait_outs(base + 2);
    do_abort();
    tick();

    // full frame with random gaps and random sink readiness
    base = out_cnt;
    d0   = done_cnt;
    rmode = 1;
    do_start(SW'($urandom));
    for (int i = 0; i < FN; i++) send(fr[i], $urandom_range(0, 3));
    wait_outs(base + FN);
    rmode = 0;
    repeat (3) tick();
    check("ff_done_count", done_cnt - d0, 1);
    check("ff_busy", busy, 0);
    check("ff_sb_empty", sb.size(), 0);

    // back-pressure: stalled run must match an unstalled run
    s = 15'h1ACE;
    got.delete();
    base = out_cnt;
    do_start(s);
    for (int i = 0; i < 4; i++) send(fr[i], 0);
    wait_outs(base + 4);
    for (int i = 0; i < 4; i++) ref_run[i] = got[i];
    do_abort();
    tick();
    got.delete();
    base = out_cnt;
    do_start(s);
    send(fr[0], 0);
    wait_outs(base + 1);
    rmode = 2;
    send(fr[1], 0);
    wait_valid();
    repeat (20) tick();
    rmode = 0;
    send(fr[2], 0);
    send(fr[3], 0);
    wait_outs(base + 4);
    for (int i = 0; i < 4; i++) check("bp_same_seq", got[i], ref_run[i]);
    do_abort();
    tick();

    // abort during SHIFT of the third nibble
    s = SW'($urandom) | 15'h0100;
    base = out_cnt;
    do_start(s);
    send(fr[5], 0);
    wait_outs(base + 1);
    first0 = last_out;
    send(fr[6], 1);
    wait_outs(base + 2);
    send(fr[7], 0);
    tick();
    do_abort();
    @(negedge clk);
    check("ab_busy", busy, 0);
    check("ab_in_ready", in_ready, 0);
    check("ab_out_valid", out_valid, 0);
    sb.delete();
    tick();
    d0   = done_cnt;
    base = out_cnt;
    repeat (12) tick();
    check("ab_no_out", out_cnt - base, 0);
    check("ab_no_done", done_cnt - d0, 0);
    do_start(s);
    send(fr[5], 0);
    wait_outs(base + 1);
    check("ab_fresh_first", last_out, first0);
    do_abort();
    tick();

    // start while in OUT is ignored
    s = 15'h2B3D;
    base = out_cnt;
    do_start(s);
    rmode = 2;
    send(4'h5, 0);
    wait_valid();
    load_cnt = 0;
    start = 1'b1;
    seed  = ~s;
    tick();
    start = 1'b0;
    @(negedge clk);
    check("so_seed_kept", lfsr_seed, s);
    check("so_busy", busy, 1);
    check("so_valid", out_valid, 1);
    rmode = 0;
    wait_outs(base + 1);
    send(4'h9, 0);
    wait_outs(base + 2);
    check("so_no_reload", load_cnt, 0);

    // synchronous reset during SHIFT
    send(4'h3, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check_reset_outs("rst_shift");
    sb.delete();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
